// File: rtl/fire_sensor_cond.sv
// fire_sensor_cond: sensor conditioning ahead of the fire controller FSM.
//
// Produces two clean levels for the controller:
//   smoke_signal - smoke_raw synchronized through two flops, then debounced.
//                  A change is taken only after SMOKE_DB consecutive cycles of
//                  the new synchronized level. Latency is SMOKE_DB+2 cycles.
//   heat_signal  - over-temperature level from a 4-state hysteresis FSM. The
//                  FSM advances only on temp_valid cycles. It needs
//                  HEAT_PERSIST consecutive hot samples (>= HEAT_ON_TH) to
//                  rise and the same number of cool samples (< HEAT_OFF_TH)
//                  to fall.
//
// Optional feature, enabled with the macro FIRE_SENSOR_FAULT_EN:
//   A stall counter counts cycles without temp_valid. After SAMPLE_TIMEOUT
//   cycles it raises sensor_fault and forces the heat FSM to HOT (fail-safe).
//   The next valid sample clears the fault and is processed from HOT.
//   With the macro undefined, sensor_fault is tied to 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   temp_data    in   [TEMP_W] unsigned temperature sample
//   temp_valid   in   temp_data valid this cycle; always accepted
//   smoke_raw    in   raw asynchronous smoke detector level
//   heat_signal  out  filtered over-temperature level (registered)
//   smoke_signal out  debounced smoke level (registered)
//   sensor_fault out  sample stream stalled (feature only, else 0)
//   heat_state   out  [2] current heat FSM state, for observation only
//                     (0=COOL 1=RISING 2=HOT 3=FALLING)
module fire_sensor_cond #(
  parameter int TEMP_W         = 8,
  parameter int HEAT_ON_TH     = 60,
  parameter int HEAT_OFF_TH    = 55,
  parameter int HEAT_PERSIST   = 4,
  parameter int SMOKE_DB       = 8,
  parameter int SAMPLE_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temp_data,
  input  logic              temp_valid,
  input  logic              smoke_raw,
  output logic              heat_signal,
  output logic              smoke_signal,
  output logic              sensor_fault,
  output logic [1:0]        heat_state
);

  typedef enum logic [1:0] {
    COOL    = 2'd0,
    RISING  = 2'd1,
    HOT     = 2'd2,
    FALLING = 2'd3
  } heat_state_t;

  localparam int SW = $clog2(SMOKE_DB + 1);
  localparam int HW = $clog2(HEAT_PERSIST + 1);

  localparam logic [SW-1:0]     SMOKE_LAST = SW'(SMOKE_DB - 1);
  localparam logic [HW-1:0]     HEAT_LAST  = HW'(HEAT_PERSIST - 1);
  localparam logic [HW-1:0]     HEAT_ONE   = HW'(1);
  localparam logic [TEMP_W-1:0] ON_TH      = TEMP_W'(HEAT_ON_TH);
  localparam logic [TEMP_W-1:0] OFF_TH     = TEMP_W'(HEAT_OFF_TH);

  // ---------------------------------------------------------------------
  // Smoke path: 2-flop synchronizer followed by the debounce counter.
  // ---------------------------------------------------------------------
  logic          smoke_meta;
  logic          smoke_s;
  logic [SW-1:0] smoke_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smoke_meta   <= 1'b0;
      smoke_s      <= 1'b0;
      smoke_cnt    <= '0;
      smoke_signal <= 1'b0;
    end else begin
      smoke_meta <= smoke_raw;
      smoke_s    <= smoke_meta;
      if (smoke_s == smoke_signal) begin
        smoke_cnt <= '0;
      end else if (smoke_cnt == SMOKE_LAST) begin
        // The counter would reach SMOKE_DB on this edge: accept the new level.
        smoke_signal <= ~smoke_signal;
        smoke_cnt    <= '0;
      end else begin
        smoke_cnt <= smoke_cnt + SW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Heat path: hysteresis FSM with persistence counter.
  // ---------------------------------------------------------------------
  heat_state_t   state;
  heat_state_t   state_n;
  logic [HW-1:0] heat_cnt;
  logic [HW-1:0] heat_cnt_n;
  logic          hot_sample;
  logic          cool_sample;

  assign hot_sample  = (temp_data >= ON_TH);
  assign cool_sample = (temp_data <  OFF_TH);
  assign heat_state  = state;

`ifdef FIRE_SENSOR_FAULT_EN
  localparam int                 STW       = $clog2(SAMPLE_TIMEOUT + 1);
  localparam logic [STW-1:0]     STALL_MAX = STW'(SAMPLE_TIMEOUT);
  logic [STW-1:0] stall_cnt;
  logic [STW-1:0] stall_cnt_n;
  logic           fault_n;
`endif

  always_comb begin
    state_n    = state;
    heat_cnt_n = heat_cnt;
    if (temp_valid) begin
      case (state)
        COOL: begin
          if (hot_sample) begin
            if (HEAT_PERSIST == 1) begin
              state_n    = HOT;
              heat_cnt_n = '0;
            end else begin
              state_n    = RISING;
              heat_cnt_n = HEAT_ONE;
            end
          end
        end
        RISING: begin
          if (!hot_sample) begin
            state_n    = COOL;
            heat_cnt_n = '0;
          end else if (heat_cnt == HEAT_LAST) begin
            state_n    = HOT;
            heat_cnt_n = '0;
          end else begin
            heat_cnt_n = heat_cnt + HEAT_ONE;
          end
        end
        HOT: begin
          // Samples inside the hysteresis band or above keep HOT.
          if (cool_sample) begin
            if (HEAT_PERSIST == 1) begin
              state_n    = COOL;
              heat_cnt_n = '0;
            end else begin
              state_n    = FALLING;
              heat_cnt_n = HEAT_ONE;
            end
          end
        end
        FALLING: begin
          if (!cool_sample) begin
            state_n    = HOT;
            heat_cnt_n = '0;
          end else if (heat_cnt == HEAT_LAST) begin
            state_n    = COOL;
            heat_cnt_n = '0;
          end else begin
            heat_cnt_n = heat_cnt + HEAT_ONE;
          end
        end
        default: begin
          state_n    = COOL;
          heat_cnt_n = '0;
        end
      endcase
    end

`ifdef FIRE_SENSOR_FAULT_EN
    stall_cnt_n = stall_cnt;
    fault_n     = sensor_fault;
    if (temp_valid) begin
      // The sample itself was already processed above from the current
      // state, which is HOT if a fault had forced it.
      stall_cnt_n = '0;
      fault_n     = 1'b0;
    end else if (stall_cnt != STALL_MAX) begin
      stall_cnt_n = stall_cnt + STW'(1);
      if (stall_cnt_n == STALL_MAX) begin
        fault_n    = 1'b1;
        state_n    = HOT;
        heat_cnt_n = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= COOL;
      heat_cnt    <= '0;
      heat_signal <= 1'b0;
    end else begin
      state       <= state_n;
      heat_cnt    <= heat_cnt_n;
      // Registered from the next state so the level moves on the same edge.
      heat_signal <= (state_n == HOT) || (state_n == FALLING);
    end
  end

`ifdef FIRE_SENSOR_FAULT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt    <= '0;
      sensor_fault <= 1'b0;
    end else begin
      stall_cnt    <= stall_cnt_n;
      sensor_fault <= fault_n;
    end
  end
`else
  assign sensor_fault = 1'b0;
  // Keeps the timeout parameter referenced in builds without the monitor.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(SAMPLE_TIMEOUT);
`endif

endmodule
